// File: rtl/hazard_controller.sv
// Pipeline sequencing for the five-stage datapath: stall/flush/bubble decisions,
// NZCV flag register, EX condition evaluation, branch resolution and forwarding selects.
module hazard_controller #(
    parameter int REG_W      = 4,
    parameter int BR_PENALTY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             ex_valid,
    input  logic             ex_wr,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_set_flags,
    input  logic [3:0]       ex_flags,
    input  logic [3:0]       ex_cond,
    input  logic             ex_is_branch,
    input  logic             mem_valid,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] mem_rd,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             br_take,
    output logic             ex_cond_pass,
    output logic [3:0]       flags,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(BR_PENALTY - 1);

    state_t     state, state_next;
    logic [1:0] cnt, cnt_next;
    logic       branch_taken, load_use;
    logic [1:0] fwd_a_next, fwd_b_next;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        case (ex_cond)
            4'h0:    ex_cond_pass = z;
            4'h1:    ex_cond_pass = !z;
            4'h2:    ex_cond_pass = c;
            4'h3:    ex_cond_pass = !c;
            4'h4:    ex_cond_pass = n;
            4'h5:    ex_cond_pass = !n;
            4'h6:    ex_cond_pass = v;
            4'h7:    ex_cond_pass = !v;
            4'h8:    ex_cond_pass = c && !z;
            4'h9:    ex_cond_pass = !c || z;
            4'hA:    ex_cond_pass = (n == v);
            4'hB:    ex_cond_pass = (n != v);
            4'hC:    ex_cond_pass = !z && (n == v);
            4'hD:    ex_cond_pass = z || (n != v);
            4'hE:    ex_cond_pass = 1'b1;
            default: ex_cond_pass = 1'b0;
        endcase
    end

    // Held in reset, the pipeline must see no stall, flush or redirect request.
    assign branch_taken = reset_n && ex_valid && ex_is_branch && ex_cond_pass && (state != FLUSH);
    assign load_use     = reset_n && (state == RUN) && id_valid && ex_valid && ex_load && ex_wr &&
                          ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));

    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                           input logic e_hit, input logic [REG_W-1:0] e_rd,
                                           input logic m_hit, input logic [REG_W-1:0] m_rd);
        if (!used)                return 2'b00;
        if (e_hit && e_rd == src) return 2'b10;
        if (m_hit && m_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a_next = fwd_sel(id_use_rn, id_rn, ex_valid && ex_wr && !ex_load, ex_rd,
                             mem_valid && mem_wr, mem_rd);
        fwd_b_next = fwd_sel(id_use_rm, id_rm, ex_valid && ex_wr && !ex_load, ex_rd,
                             mem_valid && mem_wr, mem_rd);
    end

    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise paths that skip an assignment infer latches.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        br_take     = 1'b0;
        case (state)
            FLUSH: begin
                ifid_flush  = reset_n;
                idex_bubble = reset_n;
                if (cnt <= 2'd1) begin
                    state_next = RUN;
                    cnt_next   = 2'd0;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            default: begin
                if (branch_taken) begin
                    br_take     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_INIT;
                    end else begin
                        state_next = RUN;
                    end
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    state_next  = STALL;
                end else begin
                    state_next = RUN;
                end
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update
    // together from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= 2'd0;
            flags <= 4'b0000;
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (ex_valid && ex_set_flags && ex_cond_pass && state != FLUSH)
                flags <= ex_flags;
            fwd_a <= idex_bubble ? 2'b00 : fwd_a_next;
            fwd_b <= idex_bubble ? 2'b00 : fwd_b_next;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller (BR_PENALTY=2): reset, conditions,
// flag gating, load-use stall, forwarding priority, branch vs stall, reset mid-flush.
module tb_hazard_controller;

    localparam int REG_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             id_valid, id_use_rn, id_use_rm;
    logic [REG_W-1:0] id_rn, id_rm, ex_rd, mem_rd;
    logic             ex_valid, ex_wr, ex_load, ex_set_flags, ex_is_branch;
    logic [3:0]       ex_flags, ex_cond;
    logic             mem_valid, mem_wr;
    logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, br_take, ex_cond_pass;
    logic [3:0]       flags;
    logic [1:0]       fwd_a, fwd_b;
    logic [4:0]       ctrl;

    int passed = 0;
    int total  = 0;

    hazard_controller #(.REG_W(REG_W), .BR_PENALTY(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_load(ex_load), .ex_rd(ex_rd),
        .ex_set_flags(ex_set_flags), .ex_flags(ex_flags), .ex_cond(ex_cond),
        .ex_is_branch(ex_is_branch),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .br_take(br_take), .ex_cond_pass(ex_cond_pass),
        .flags(flags), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #10 clk = ~clk;

    assign ctrl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, br_take};

    task automatic idle();
        id_valid = 0; id_use_rn = 0; id_use_rm = 0; id_rn = 0; id_rm = 0;
        ex_valid = 0; ex_wr = 0; ex_load = 0; ex_rd = 0; ex_set_flags = 0;
        ex_flags = 0; ex_cond = 0; ex_is_branch = 0;
        mem_valid = 0; mem_wr = 0; mem_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        #5;
        total++; if (ctrl !== 5'b00000) $display("FAIL reset_ctrl: got %b want 00000", ctrl); else passed++;
        total++; if (flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags); else passed++;
        total++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b}); else passed++;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_conditions();
        logic [3:0]  fl [4] = '{4'b0110, 4'b1001, 4'b0010, 4'b1000};
        logic [15:0] mk [4] = '{16'h66A5, 16'h565A, 16'h55A6, 16'h6A9A};
        logic [15:0] got;
        for (int i = 0; i < 4; i++) begin
            idle();
            ex_valid = 1; ex_set_flags = 1; ex_cond = 4'hE; ex_flags = fl[i];
            tick();
            total++; if (flags !== fl[i]) $display("FAIL cond_set_flags[%0d]: got %b want %b", i, flags, fl[i]); else passed++;
            idle();
            for (int k = 0; k < 16; k++) begin
                ex_cond = k[3:0];
                #1;
                got[k] = ex_cond_pass;
            end
            total++; if (got !== mk[i]) $display("FAIL cond_pass_flags_%b: got %h want %h", fl[i], got, mk[i]); else passed++;
            tick();
        end
    endtask

    task automatic test_flag_gating();
        idle();
        ex_valid = 1; ex_set_flags = 1; ex_cond = 4'h0; ex_flags = 4'b0100;
        #1;
        total++; if (ex_cond_pass !== 1'b0) $display("FAIL gate_eq_pass: got %b want 0", ex_cond_pass); else passed++;
        tick();
        total++; if (flags !== 4'b1000) $display("FAIL gate_cond_fail: got %b want 1000", flags); else passed++;
        ex_cond = 4'h1;
        tick();
        total++; if (flags !== 4'b0100) $display("FAIL gate_cond_pass: got %b want 0100", flags); else passed++;
        ex_valid = 0; ex_cond = 4'hE; ex_flags = 4'b1111;
        tick();
        total++; if (flags !== 4'b0100) $display("FAIL gate_not_valid: got %b want 0100", flags); else passed++;
        idle();
    endtask

    task automatic test_load_use();
        idle();
        ex_valid = 1; ex_wr = 1; ex_load = 1; ex_rd = 3;
        id_valid = 1; id_use_rn = 1; id_rn = 3; id_use_rm = 1; id_rm = 7;
        mem_valid = 1; mem_wr = 1; mem_rd = 7;
        #1;
        total++; if (ctrl !== 5'b11010) $display("FAIL lu_detect: got %b want 11010", ctrl); else passed++;
        tick();
        total++; if (fwd_b !== 2'b00) $display("FAIL lu_bubble_fwd: got %b want 00", fwd_b); else passed++;
        mem_rd = 3;
        #1;
        total++; if (ctrl !== 5'b00000) $display("FAIL lu_stall_cycle: got %b want 00000", ctrl); else passed++;
        tick();
        total++; if ({fwd_a, fwd_b} !== 4'b0100) $display("FAIL lu_fwd_after: got %b want 0100", {fwd_a, fwd_b}); else passed++;
        idle();
        tick();
    endtask

    task automatic test_forward();
        idle();
        ex_valid = 1; ex_wr = 1; ex_rd = 5;
        mem_valid = 1; mem_wr = 1; mem_rd = 5;
        id_valid = 1; id_use_rm = 1; id_rm = 5; id_use_rn = 1; id_rn = 2;
        #1;
        total++; if (ctrl !== 5'b00000) $display("FAIL fwd_no_stall: got %b want 00000", ctrl); else passed++;
        tick();
        total++; if ({fwd_a, fwd_b} !== 4'b0010) $display("FAIL fwd_ex_priority: got %b want 0010", {fwd_a, fwd_b}); else passed++;
        id_use_rm = 0; id_rn = 5;
        tick();
        total++; if ({fwd_a, fwd_b} !== 4'b1000) $display("FAIL fwd_unused_src: got %b want 1000", {fwd_a, fwd_b}); else passed++;
        ex_wr = 0;
        tick();
        total++; if (fwd_a !== 2'b01) $display("FAIL fwd_mem: got %b want 01", fwd_a); else passed++;
        mem_valid = 0;
        tick();
        total++; if (fwd_a !== 2'b00) $display("FAIL fwd_none: got %b want 00", fwd_a); else passed++;
        idle();
    endtask

    task automatic test_branch_vs_stall();
        idle();
        ex_valid = 1; ex_is_branch = 1; ex_cond = 4'h0;
        ex_wr = 1; ex_load = 1; ex_rd = 3;
        id_valid = 1; id_use_rn = 1; id_rn = 3;
        mem_valid = 1; mem_wr = 1; mem_rd = 3;
        #1;
        total++; if (ctrl !== 5'b00111) $display("FAIL br_over_stall: got %b want 00111", ctrl); else passed++;
        tick();
        ex_set_flags = 1; ex_cond = 4'hE; ex_flags = 4'b1111;
        #1;
        total++; if (ctrl !== 5'b00110) $display("FAIL br_flush_hold: got %b want 00110", ctrl); else passed++;
        total++; if (fwd_a !== 2'b00) $display("FAIL br_bubble_fwd: got %b want 00", fwd_a); else passed++;
        tick();
        total++; if (flags !== 4'b0100) $display("FAIL flush_flag_gate: got %b want 0100", flags); else passed++;
        total++; if (fwd_a !== 2'b00) $display("FAIL flush_fwd: got %b want 00", fwd_a); else passed++;
        idle();
        #1;
        total++; if (ctrl !== 5'b00000) $display("FAIL br_flush_end: got %b want 00000", ctrl); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        idle();
        ex_valid = 1; ex_is_branch = 1; ex_cond = 4'h0;
        tick();
        idle();
        #1;
        total++; if (ctrl !== 5'b00110) $display("FAIL rst_in_flush: got %b want 00110", ctrl); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (ctrl !== 5'b00000) $display("FAIL rst_ctrl: got %b want 00000", ctrl); else passed++;
        total++; if (flags !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", flags); else passed++;
        total++; if (ex_cond_pass !== 1'b0) $display("FAIL rst_eq_pass: got %b want 0", ex_cond_pass); else passed++;
        tick();
        reset_n = 1'b1;
        #1;
        total++; if (ctrl !== 5'b00000) $display("FAIL rst_no_residual: got %b want 00000", ctrl); else passed++;
        tick();
        total++; if ({ctrl, fwd_a, fwd_b} !== 9'b0) $display("FAIL rst_run_after: got %b want 0", {ctrl, fwd_a, fwd_b}); else passed++;
    endtask

    initial begin
        test_reset();
        test_conditions();
        test_flag_gating();
        test_load_use();
        test_forward();
        test_branch_vs_stall();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
